// File: rtl/mask_motion_ctrl.sv
// Mask motion controller: game-run FSM, motion step divider, respawn LFSR and score.
// Optional build macro MASK_SPEEDUP_EN raises the step size with the score.
module mask_motion_ctrl #(
  parameter int unsigned TICK_DIV    = 250000,
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SPEED       = 2,
  parameter int unsigned TOP_Y       = 40,
  parameter int unsigned BOTTOM_Y    = 420,
  parameter int unsigned CRAZY_Y_MIN = 100,
  parameter int unsigned CRAZY_Y_MAX = 340
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        collision,
  output logic [9:0]  mask_top_x,
  output logic [9:0]  mask_top_y,
  output logic [9:0]  mask_bottom_x,
  output logic [9:0]  mask_bottom_y,
  output logic [9:0]  mask_crazy_x,
  output logic [9:0]  mask_crazy_y,
  output logic        running,
  output logic        game_over,
  output logic [15:0] score
);

  localparam logic [9:0]  XSpawn   = 10'(SCREEN_W);
  localparam logic [9:0]  BotX0    = 10'(SCREEN_W + 160);
  localparam logic [9:0]  CrzX0    = 10'(SCREEN_W + 320);
  localparam logic [9:0]  YMin     = 10'(CRAZY_Y_MIN);
  localparam logic [9:0]  YMax     = 10'(CRAZY_Y_MAX);
  localparam logic [19:0] TickLast = 20'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StRun, StHit} state_e;

  state_e      state_q, state_d;
  logic [19:0] tick_q, tick_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] score_q, score_d;
  logic [9:0]  top_x_q, top_x_d;
  logic [9:0]  bot_x_q, bot_x_d;
  logic [9:0]  crz_x_q, crz_x_d;
  logic [9:0]  crz_y_q, crz_y_d;
  logic        crz_up_q, crz_up_d;

  logic        step, reload;
  logic [9:0]  step_sz;
  logic        top_wrap, bot_wrap, crz_wrap;
  logic [1:0]  wrap_cnt;
  logic [16:0] score_sum;
  logic [10:0] spawn_sum;
  logic [9:0]  spawn_y, crz_y_mv;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      tick_q   <= '0;
      lfsr_q   <= 16'hACE1;
      score_q  <= '0;
      top_x_q  <= XSpawn;
      bot_x_q  <= BotX0;
      crz_x_q  <= CrzX0;
      crz_y_q  <= YMin;
      crz_up_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      lfsr_q   <= lfsr_d;
      score_q  <= score_d;
      top_x_q  <= top_x_d;
      bot_x_q  <= bot_x_d;
      crz_x_q  <= crz_x_d;
      crz_y_q  <= crz_y_d;
      crz_up_q <= crz_up_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (collision) state_d = StHit;
      StHit:   if (start) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    running   = (state_q == StRun);
    game_over = (state_q == StHit);
  end

`ifdef MASK_SPEEDUP_EN
  // One extra pixel per 8 masks passed, capped at +3; uses the pre-step score.
  always_comb begin
    if (score_q[15:3] > 13'd3) step_sz = 10'(SPEED) + 10'd3;
    else                       step_sz = 10'(SPEED) + {8'd0, score_q[4:3]};
  end
`else
  assign step_sz = 10'(SPEED);
`endif

  assign step      = (state_q == StRun) && !collision && (tick_q == TickLast);
  assign reload    = start && (state_q != StRun);
  assign top_wrap  = top_x_q < step_sz;
  assign bot_wrap  = bot_x_q < step_sz;
  assign crz_wrap  = crz_x_q < step_sz;
  assign wrap_cnt  = {1'b0, top_wrap} + {1'b0, bot_wrap} + {1'b0, crz_wrap};
  assign score_sum = {1'b0, score_q} + {15'd0, wrap_cnt};
  assign spawn_sum = 11'(CRAZY_Y_MIN) + {3'b000, lfsr_q[7:0]};
  assign spawn_y   = (spawn_sum > 11'(CRAZY_Y_MAX)) ? YMax : spawn_sum[9:0];
  assign crz_y_mv  = crz_up_q ? crz_y_q - 10'd1 : crz_y_q + 10'd1;

  // Datapath next state
  always_comb begin
    lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    tick_d   = '0;
    score_d  = score_q;
    top_x_d  = top_x_q;
    bot_x_d  = bot_x_q;
    crz_x_d  = crz_x_q;
    crz_y_d  = crz_y_q;
    crz_up_d = crz_up_q;
    if (state_q == StRun) tick_d = (tick_q == TickLast) ? '0 : tick_q + 20'd1;
    if (reload) begin
      score_d  = '0;
      top_x_d  = XSpawn;
      bot_x_d  = BotX0;
      crz_x_d  = CrzX0;
      crz_y_d  = YMin;
      crz_up_d = 1'b0;
    end else if (step) begin
      score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
      top_x_d = top_wrap ? XSpawn : top_x_q - step_sz;
      bot_x_d = bot_wrap ? XSpawn : bot_x_q - step_sz;
      crz_x_d = crz_wrap ? XSpawn : crz_x_q - step_sz;
      if (crz_wrap) begin
        crz_y_d  = spawn_y;
        crz_up_d = 1'b0;
      end else begin
        crz_y_d = crz_y_mv;
        if (crz_y_mv >= YMax)      crz_up_d = 1'b1;
        else if (crz_y_mv <= YMin) crz_up_d = 1'b0;
      end
    end
  end

  assign mask_top_x    = top_x_q;
  assign mask_top_y    = 10'(TOP_Y);
  assign mask_bottom_x = bot_x_q;
  assign mask_bottom_y = 10'(BOTTOM_Y);
  assign mask_crazy_x  = crz_x_q;
  assign mask_crazy_y  = crz_y_q;
  assign score         = score_q;

endmodule

// File: tb/tb_mask_motion_ctrl.sv
// Bench for mask_motion_ctrl: per-cycle comparison against a game-rule model plus
// hand-computed checkpoints along a single game.
module tb_mask_motion_ctrl;

  localparam int TICK_DIV = 4;
  localparam int SPEED    = 2;

  logic        clk, rst, start, collision;
  logic [9:0]  mask_top_x, mask_top_y, mask_bottom_x, mask_bottom_y;
  logic [9:0]  mask_crazy_x, mask_crazy_y;
  logic        running, game_over;
  logic [15:0] score;

  int checks = 0;
  int errors = 0;

  mask_motion_ctrl #(
    .TICK_DIV(TICK_DIV),
    .SPEED   (SPEED)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .collision    (collision),
    .mask_top_x   (mask_top_x),
    .mask_top_y   (mask_top_y),
    .mask_bottom_x(mask_bottom_x),
    .mask_bottom_y(mask_bottom_y),
    .mask_crazy_x (mask_crazy_x),
    .mask_crazy_y (mask_crazy_y),
    .running      (running),
    .game_over    (game_over),
    .score        (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Game model: 0 idle, 1 run, 2 hit
  int          m_state, m_cnt, m_steps;
  int          m_top, m_bot, m_crz, m_cy, m_score;
  bit          m_up;
  logic [15:0] m_lfsr;

  task automatic model_reload();
    m_top = 640; m_bot = 800; m_crz = 960; m_cy = 100; m_up = 0;
    m_score = 0; m_cnt = 0;
  endtask

  task automatic model_step(input logic [15:0] l);
    int s, wraps, sum;
    s = SPEED;
`ifdef MASK_SPEEDUP_EN
    s = s + ((m_score / 8 > 3) ? 3 : m_score / 8);
`endif
    wraps = 0;
    if (m_top < s) begin m_top = 640; wraps++; end else m_top = m_top - s;
    if (m_bot < s) begin m_bot = 640; wraps++; end else m_bot = m_bot - s;
    if (m_crz < s) begin
      m_crz = 640; wraps++;
      m_cy  = 100 + int'(l[7:0]);
      if (m_cy > 340) m_cy = 340;
      m_up  = 0;
    end else begin
      m_crz = m_crz - s;
      m_cy  = m_up ? m_cy - 1 : m_cy + 1;
      if (m_cy >= 340) m_up = 1;
      else if (m_cy <= 100) m_up = 0;
    end
    sum = m_score + wraps;
    m_score = (sum > 65535) ? 65535 : sum;
    m_steps++;
  endtask

  task automatic model_clock();
    logic [15:0] l_old;
    l_old = m_lfsr;
    if (!rst) begin
      model_reload();
      m_state = 0;
      m_lfsr  = 16'hACE1;
    end else begin
      m_lfsr = {l_old[0] ^ l_old[2] ^ l_old[3] ^ l_old[5], l_old[15:1]};
      case (m_state)
        0: if (start) begin m_state = 1; m_cnt = 0; end
        1: begin
          if (collision) m_state = 2;
          else if (m_cnt == TICK_DIV - 1) begin m_cnt = 0; model_step(l_old); end
          else m_cnt++;
        end
        default: if (start) begin model_reload(); m_state = 1; end
      endcase
    end
  endtask

  initial begin
    m_steps = 0; m_state = 0; m_lfsr = 16'hACE1;
    model_reload();
    forever begin
      @(posedge clk);
      model_clock();
    end
  end

  // Per-cycle compare
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("top_x",    int'(mask_top_x),    m_top);
        check("top_y",    int'(mask_top_y),    40);
        check("bottom_x", int'(mask_bottom_x), m_bot);
        check("bottom_y", int'(mask_bottom_y), 420);
        check("crazy_x",  int'(mask_crazy_x),  m_crz);
        check("crazy_y",  int'(mask_crazy_y),  m_cy);
        check("running",  int'(running),       int'(m_state == 1));
        check("game_over", int'(game_over),    int'(m_state == 2));
        check("score",    int'(score),         m_score);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

  task automatic wait_step(input int target);
    int guard;
    guard = 0;
    while (m_steps < target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check("step_reached", m_steps, target);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  initial begin
    int guard;
    rst = 1'b0; start = 1'b0; collision = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_top_x",   int'(mask_top_x), 640);
    check("idle_bot_x",   int'(mask_bottom_x), 800);
    check("idle_crazy_x", int'(mask_crazy_x), 960);
    check("idle_crazy_y", int'(mask_crazy_y), 100);
    check("idle_running", int'(running), 0);
    check("idle_score",   int'(score), 0);

    pulse_start();
    repeat (3) @(negedge clk);
    check("pre_step_top_x", int'(mask_top_x), 640);
    @(negedge clk);
    check("run_running",   int'(running), 1);
    check("step1_top_x",   int'(mask_top_x), 638);
    check("step1_bot_x",   int'(mask_bottom_x), 798);
    check("step1_crazy_x", int'(mask_crazy_x), 958);
    check("step1_crazy_y", int'(mask_crazy_y), 101);

    wait_step(100);
    pulse_start();  // ignored while running

    wait_step(239);
    check("s239_crazy_y", int'(mask_crazy_y), 339);
    wait_step(240);
    check("s240_crazy_y", int'(mask_crazy_y), 340);
    wait_step(241);
    check("s241_crazy_y", int'(mask_crazy_y), 339);
    wait_step(320);
    check("s320_top_x", int'(mask_top_x), 0);
    check("s320_score", int'(score), 0);
    wait_step(321);
    check("s321_top_x",   int'(mask_top_x), 640);
    check("s321_score",   int'(score), 1);
    check("s321_bot_x",   int'(mask_bottom_x), 158);
    check("s321_crazy_x", int'(mask_crazy_x), 318);
    check("s321_crazy_y", int'(mask_crazy_y), 259);
    wait_step(490);
    check("s490_top_x",   int'(mask_top_x), 302);
    check("s490_bot_x",   int'(mask_bottom_x), 462);
    check("s490_crazy_x", int'(mask_crazy_x), 622);
    check("s490_score",   int'(score), 3);

    // Collision on the step-tick cycle
    guard = 0;
    while (m_cnt != TICK_DIV - 1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("tick_aligned", m_cnt, TICK_DIV - 1);
    collision = 1'b1;
    @(negedge clk);
    collision = 1'b0;
    check("hit_game_over", int'(game_over), 1);
    check("hit_running",   int'(running), 0);
    check("hit_top_x",     int'(mask_top_x), 302);
    repeat (200) @(negedge clk);
    check("frozen_top_x",   int'(mask_top_x), 302);
    check("frozen_bot_x",   int'(mask_bottom_x), 462);
    check("frozen_crazy_x", int'(mask_crazy_x), 622);
    check("frozen_score",   int'(score), 3);

    pulse_start();
    check("restart_top_x",   int'(mask_top_x), 640);
    check("restart_bot_x",   int'(mask_bottom_x), 800);
    check("restart_crazy_x", int'(mask_crazy_x), 960);
    check("restart_crazy_y", int'(mask_crazy_y), 100);
    check("restart_score",   int'(score), 0);
    check("restart_running", int'(running), 1);
    repeat (4) @(negedge clk);
    check("restart_step_top_x",   int'(mask_top_x), 638);
    check("restart_step_crazy_y", int'(mask_crazy_y), 101);

    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_running", int'(running), 0);
    check("async_rst_top_x",   int'(mask_top_x), 640);
    check("async_rst_score",   int'(score), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mask_motion_ctrl.md
Name: mask_motion_ctrl

Overview:
Producer side of the collision interface. Generates the per-frame positions of the three masks (top, bottom, crazy) that the collision checker compares against JOJO, and consumes its collision flag to freeze play. Contains the game-run FSM, frame-step divider, respawn LFSR and the score counter. Sits between the top-level game controller and the collision checker / VGA sprite renderer.

Parameters:
TICK_DIV, 250000, clocks per motion step (≥2); the tick counter is 20 bits.
SCREEN_W, 640, x value at which masks spawn, just off the right edge.
SPEED, 2, base pixels moved left per step (1..15).
TOP_Y, 40, fixed y of the top mask.
BOTTOM_Y, 420, fixed y of the bottom mask.
CRAZY_Y_MIN, 100, lower y bound of the crazy mask.
CRAZY_Y_MAX, 340, upper y bound of the crazy mask.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (asserted at 0)
start  in  1  single-cycle pulse: begin/restart game
collision  in  1  registered collision flag from the checker
mask_top_x, mask_top_y  out  10 each  top mask position
mask_bottom_x, mask_bottom_y  out  10 each  bottom mask position
mask_crazy_x, mask_crazy_y  out  10 each  crazy mask position
running  out  1  high in RUN
game_over  out  1  high in HIT
score  out  16  masks passed, saturating

Behaviour:
- Reset values (rst=0): FSM=IDLE; tick counter=0; LFSR=16'hACE1; score=0; running=0; game_over=0; top_x=SCREEN_W, top_y=TOP_Y; bottom_x=SCREEN_W+160, bottom_y=BOTTOM_Y; crazy_x=SCREEN_W+320, crazy_y=CRAZY_Y_MIN; crazy direction=down. All outputs are registered.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; shifts every clock in every state.
- States: IDLE, RUN, HIT.
  - IDLE: positions held at their reset values. start=1 → RUN on the next edge; tick counter cleared.
  - RUN: tick counter counts 0..TICK_DIV-1 and wraps. A step occurs on the cycle the counter equals TICK_DIV-1. collision=1 → HIT on the next edge. Collision takes priority over a step in the same cycle: no position update, no score update. start is ignored.
  - HIT: all positions frozen; game_over=1. start=1 → reload every reset value except the LFSR, clear score, go to RUN. collision is ignored.
- Step, per mask, with step size s (=SPEED unless the optional feature is enabled):
  - If x < s: x ← SCREEN_W (respawn) and score increments, saturating at 16'hFFFF. Otherwise x ← x − s. x never underflows.
  - The score adds the number of masks respawning in that step (0..3), still saturating.
- Crazy y, evaluated each step:
  - Direction down: y+1.
  - Direction up: y−1.
  - When the updated y reaches CRAZY_Y_MAX, the direction becomes up; when it reaches CRAZY_Y_MIN, the direction becomes down.
  - On a crazy respawn: y ← min(CRAZY_Y_MIN + LFSR[7:0], CRAZY_Y_MAX), direction ← down.
- Top and bottom y are constant.
- Latency: a position change is visible on the outputs 1 clock after the step cycle. The collision checker adds 1 cycle, so the freeze lands at most one step late. That is acceptable.
- Width: arithmetic is 10-bit unsigned; CRAZY_Y_MIN+255 is computed in 11 bits before the clamp.
- Reset asserted mid-game returns to IDLE immediately (asynchronous); start seen during reset is lost.

Optional Feature:
MASK_SPEEDUP_EN
- Defined: s = SPEED + min(score[15:3], 3). Speed rises every 8 masks passed, up to +3 px/step. s is sampled from the pre-step score.
- Undefined: s = SPEED constant; no extra logic.

Test Plan:
- Reset, then idle 100 cycles with no start (TICK_DIV=4) → top_x=640, bottom_x=800, crazy_x=960, crazy_y=100, running=0, score=0.
- start pulse, run 4 clocks (TICK_DIV=4) → running=1; exactly one step; top_x=638, bottom_x=798, crazy_x=958, crazy_y=101.
- Force top_x to 1 in RUN, then step → top_x=640, score +1; bottom_x and crazy_x each decrease by 2.
- collision=1 in the same cycle as a step tick → no position change; next edge game_over=1, running=0; positions stay frozen for 50 ticks even with collision deasserted.
- In HIT, pulse start → all positions back to their reset values, score=0, running=1, next step moves masks normally.
- Crazy at y=339 moving down, step → y=340, direction up; next step → 339. Crazy respawn with LFSR[7:0]=8'hFF → crazy_y=340 (clamped).
